// File: rtl/hold_pkg.sv
// Shared types and widths for the climbing-wall hold table and its hit testers.
package hold_pkg;

    localparam int COORD_W = 13;
    localparam int SUM_W   = 14;
    localparam int HOLD_W  = 32;
    localparam int HOLD_H  = 8;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } hold_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } qstate_t;

    // Zero-extend a world coordinate so edge sums cannot wrap.
    function automatic logic [SUM_W-1:0] widen(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/hold_hit_test.sv
// Combinational containment check of one world-space point against one hold rectangle.
module hold_hit_test
    import hold_pkg::*;
#(
    parameter int WIDTH  = HOLD_W,
    parameter int HEIGHT = HOLD_H
) (
    input  logic [SUM_W-1:0] px,
    input  logic [SUM_W-1:0] py,
    input  hold_t            hold,
    output logic             hit
);

    logic [SUM_W-1:0] x0;
    logic [SUM_W-1:0] x1;
    logic [SUM_W-1:0] y0;
    logic [SUM_W-1:0] y1;

    always_comb begin
        x0  = widen(hold.x);
        y0  = widen(hold.y);
        x1  = x0 + SUM_W'(WIDTH);
        y1  = y0 + SUM_W'(HEIGHT);
        hit = hold.valid && (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    end

endmodule

// File: rtl/hold_array.sv
// Hold table with a 2-stage per-pixel hit tester and a sequential point-query scanner.
module hold_array
    import hold_pkg::*;
#(
    parameter int NUM_HOLDS = 16,
    parameter int WIDTH     = HOLD_W,
    parameter int HEIGHT    = HOLD_H,
    parameter int IDX_W     = $clog2(NUM_HOLDS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [10:0]        hcount,
    input  logic [9:0]         vcount,
    input  logic [COORD_W-1:0] screenx,
    input  logic [COORD_W-1:0] screeny,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               wr_valid,
    output logic               pix_hit,
    output logic [IDX_W-1:0]   pix_index,
    input  logic               q_start,
    input  logic [COORD_W-1:0] q_x,
    input  logic [COORD_W-1:0] q_y,
    output logic               q_busy,
    output logic               q_done,
    output logic               q_found,
    output logic [IDX_W-1:0]   q_index
);

    hold_t holds [NUM_HOLDS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_HOLDS; i++) begin
                holds[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            holds[wr_addr] <= '{valid: wr_valid, x: wr_x, y: wr_y};
        end
    end

    logic [SUM_W-1:0]     px;
    logic [SUM_W-1:0]     py;
    logic [NUM_HOLDS-1:0] pix_hits;
    logic                 hit_any;
    logic [IDX_W-1:0]     hit_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else begin
            px <= SUM_W'(hcount) + widen(screenx);
            py <= SUM_W'(vcount) + widen(screeny);
        end
    end

    for (genvar g = 0; g < NUM_HOLDS; g++) begin : g_pix
        hold_hit_test #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hit (
            .px  (px),
            .py  (py),
            .hold(holds[g]),
            .hit (pix_hits[g])
        );
    end

    // Lowest index wins: first set bit encountered locks the result.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_HOLDS; i++) begin
            if (pix_hits[i] && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_hit   <= 1'b0;
            pix_index <= '0;
        end else begin
            pix_hit   <= hit_any;
            pix_index <= hit_idx;
        end
    end

    qstate_t            state;
    qstate_t            state_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [COORD_W-1:0] qx;
    logic [COORD_W-1:0] qx_next;
    logic [COORD_W-1:0] qy;
    logic [COORD_W-1:0] qy_next;
    logic               found;
    logic               found_next;
    logic [IDX_W-1:0]   index;
    logic [IDX_W-1:0]   index_next;
    logic               scan_hit;

    hold_hit_test #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_scan_hit (
        .px  (widen(qx)),
        .py  (widen(qy)),
        .hold(holds[idx]),
        .hit (scan_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            qx    <= '0;
            qy    <= '0;
            found <= 1'b0;
            index <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            qx    <= qx_next;
            qy    <= qy_next;
            found <= found_next;
            index <= index_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        qx_next    = qx;
        qy_next    = qy;
        found_next = found;
        index_next = index;
        case (state)
            IDLE: begin
                if (q_start) begin
                    qx_next    = q_x;
                    qy_next    = q_y;
                    idx_next   = '0;
                    found_next = 1'b0;
                    index_next = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    found_next = 1'b1;
                    index_next = idx;
                    state_next = DONE;
                end else if (idx == IDX_W'(NUM_HOLDS - 1)) begin
                    found_next = 1'b0;
                    index_next = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign q_busy  = (state != IDLE);
    assign q_done  = (state == DONE);
    assign q_found = found;
    assign q_index = index;

endmodule

// File: doc/hold_array.md
# hold_array

Multi-handhold table and hit-tester for the climbing wall. Stores up to `NUM_HOLDS` rectangular holds in world coordinates. Every pixel clock it reports whether the current VGA pixel, after the screen scroll offset is applied, lies on any hold. A sequential scan FSM answers "which hold is under this point" queries from the climber hand logic. It sits between the level loader (writes) and the video mixer / climber physics (reads).

## Interface

Parameters:
- `NUM_HOLDS`, 16: table depth; power of two, ≥2.
- `WIDTH`, 32: hold width in pixels.
- `HEIGHT`, 8: hold height in pixels.
- `IDX_W`, $clog2(NUM_HOLDS): index width.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `hcount` in 11: current pixel column.
- `vcount` in 10: current pixel row.
- `screenx`, `screeny` in 13 each: world coordinate of the screen's top-left corner.
- `wr_en` in 1: write one table entry this cycle.
- `wr_addr` in IDX_W: entry to write.
- `wr_x`, `wr_y` in 13 each: hold top-left corner, world coordinates.
- `wr_valid` in 1: enable bit stored with the entry; 0 deletes the hold.
- `pix_hit` out 1: the pixel presented 2 cycles earlier lies on a valid hold.
- `pix_index` out IDX_W: lowest-index hold hit by that pixel; 0 when `pix_hit`=0.
- `q_start` in 1: start a point query; sampled only in IDLE.
- `q_x`, `q_y` in 13 each: query point, world coordinates; captured on accept.
- `q_busy` out 1: high in SCAN and DONE.
- `q_done` out 1: one-cycle pulse, high in DONE.
- `q_found` out 1: result; valid while `q_done`=1 and held until the next accept.
- `q_index` out IDX_W: matching entry; 0 if not found.

## Operation

- **Table.** `NUM_HOLDS` entries, each {valid, x[12:0], y[12:0]}.
  - Reset clears every valid bit. x and y are don't-care after reset.
  - A write updates its entry at the clock edge. Readers in the same cycle see the old contents.
- **Containment rule.** Point (px,py) is on hold e iff all of the following hold:
  - e.valid
  - px ≥ e.x and px < e.x+WIDTH
  - py ≥ e.y and py < e.y+HEIGHT
- **Arithmetic width.** All sums are 14 bits, zero-extended, so there is no wrap-around:
  - px = hcount + screenx
  - py = vcount + screeny
  - e.x+WIDTH and e.y+HEIGHT
  - A hold at x=8191 is hit only at px=8191…8191+WIDTH−1.
- **Pixel path.**
  - Stage 1: register px, py.
  - Stage 2: compare all entries in parallel, priority-encode the lowest index, register `pix_hit` and `pix_index`.
- **Query FSM.** States IDLE → SCAN → DONE → IDLE.
  - IDLE: `q_start`=1 captures q_x, q_y; idx←0; go to SCAN.
  - SCAN: test entry idx against the captured point.
    - Match: latch found=1 and index=idx; go to DONE.
    - idx=NUM_HOLDS−1 with no match: found=0, index=0; go to DONE.
    - Otherwise: idx+1.
  - DONE: `q_done`=1 for one cycle, then IDLE.
  - `q_start` in SCAN or DONE is ignored, not queued.
- **Writes during a scan.** Legal. An entry written before the scan reaches it is seen with its new value. An entry written in the same cycle it is tested is seen with its old value.
- **Reset mid-query.** Returns to IDLE and clears `q_done`, `q_found` and `q_index`. No done pulse is issued.

## Timing

- Reset values: `pix_hit`=0, `pix_index`=0, `q_busy`=0, `q_done`=0, `q_found`=0, `q_index`=0, FSM=IDLE.
- Pixel latency is fixed at 2 cycles, one result per cycle, with no stalls. The mixer delays hsync/vsync by 2 to match.
- Query latency, counting the `q_start` accept cycle as cycle 0:
  - Match at entry i: `q_done` in cycle i+2.
  - No match: `q_done` in cycle NUM_HOLDS+1.
- Back-to-back queries: the earliest next accept is the cycle after DONE.
- The pixel path and the query path are fully independent. Simultaneous activity on both is legal.

## Structure

- Package `hold_pkg`:
  - `COORD_W`=13, `SUM_W`=14
  - Default `HOLD_W`=32 and `HOLD_H`=8
  - `hold_t` struct {valid, x, y}
  - `qstate_t` enum {IDLE, SCAN, DONE}
- Sub-module `hold_hit_test`: combinational containment check of one point against one `hold_t`, with WIDTH/HEIGHT parameters.
  - Instantiated NUM_HOLDS times in the pixel path and once in the scan path.

## Test plan

1. Reset, then sweep a full frame with screenx=screeny=0 → `pix_hit` never asserts.
2. Write entry 3 = (100,50,valid) and present hcount=100, vcount=50 → two cycles later `pix_hit`=1, `pix_index`=3. At hcount=132 (x+WIDTH) or vcount=58 (y+HEIGHT) → `pix_hit`=0.
3. Entries 2 and 5 both cover (200,200), with screenx=150, screeny=190, hcount=50, vcount=10 → `pix_index`=2. Rewrite entry 2 with valid=0 → `pix_index`=5.
4. Query (205,203) with only entry 5 matching, NUM_HOLDS=16 → `q_done` in cycle 7, `q_found`=1, `q_index`=5. Query (0,0) with no match → `q_done` in cycle 17, `q_found`=0. `q_start` pulses during the scan are ignored.
5. Entry at x=8191, hcount=10, screenx=8185 → px=8195 hits; px does not wrap to 3.
6. Assert `reset` in cycle 4 of a scan → next cycle FSM=IDLE, `q_busy`=0, no `q_done` pulse, all valid bits cleared.
